clk_monitor: RTL and testbench
==============================

# clk_monitor

- Synthesizable measurement stage that sits directly downstream of `clk_generator`.
- Samples `clk_out_ref` and `clk_out_phase` asynchronously against a faster system clock, then reports:
  - period and high time of the reference;
  - phase lag of the phase output, in system-clock cycles.
- Used on-chip and in benches to check that generated frequency, duty cycle and phase match configuration.

## Interface
Parameters:
- `CNT_W`, 16: width of all count results.
- `SYNC_STAGES`, 2: synchronizer depth per monitored input (≥2).
- `TIMEOUT`, 65535: cycle limit per measurement; must be ≤ 2^CNT_W−1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `en` input 1: block enable.
- `start` input 1: single-cycle measurement request.
- `mon_ref` input 1: async, from `clk_out_ref`.
- `mon_phase` input 1: async, from `clk_out_phase`.
- `busy` output 1: measurement in progress.
- `done` output 1: one-cycle completion pulse.
- `period` output CNT_W: ref rise to next ref rise.
- `high_time` output CNT_W: ref rise to ref fall.
- `phase_lag` output CNT_W: ref rise to first phase rise.
- `phase_valid` output 1: a phase rise was seen in the window.
- `timeout_err` output 1: last measurement timed out.
- `duty_pct` output 7: floor(100·high_time/period); present only with the macro.

## Operation
- Both inputs pass through `SYNC_STAGES` flops. Rise and fall are detected against one extra delay flop.
- FSM states: IDLE, ARM, MEAS, CALC (macro only), DONE.
  - IDLE: `start` & `en` → ARM. `start` is ignored when `en`=0 or `busy`=1.
  - ARM: wait for ref rise. On it, clear cnt to 0 → MEAS. A phase rise in the same cycle captures `phase_lag`=0.
  - MEAS: cnt increments every cycle, so the value captured for an event is its cycle distance from the arming rise.
    - First ref fall → `high_time`.
    - First phase rise → `phase_lag`, and `phase_valid`=1.
    - Next ref rise → `period`, then → CALC or DONE.
    - A phase rise coincident with the closing ref rise, when none was seen earlier, captures lag 0 with `phase_valid`=1.
  - CALC: 7-iteration restoring divide of (100·high_time) by `period`, then → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Timeout: cnt in ARM or MEAS reaches `TIMEOUT` → DONE with `timeout_err`=1. Result registers keep their previous values.
- `timeout_err` and `phase_valid` clear on the accepted `start`.
- `en`=0 in any state forces IDLE on the next edge. No `done` is issued and results are retained.
- `busy`=1 in ARM, MEAS and CALC.
- Results update only at the capture points and are stable whenever `busy`=0.
- cnt never wraps: the timeout fires first.
- Reset: every output and register goes to 0 and the FSM goes to IDLE, including when reset is asserted mid-measurement.

## Timing
- `start` accepted at edge N → `busy`=1 from N+1.
- Input edge to detection: SYNC_STAGES+1 cycles. Applied identically to both inputs, so relative measurements are latency-free.
- Closing ref rise detected in cycle M:
  - macro off: `done` at M+1;
  - macro on: `done` at M+8.
- Timeout: `done` is asserted one cycle after cnt equals `TIMEOUT`.
- Measurement resolution is ±1 cycle for inputs not phase-locked to `clk`.

## Configuration
- `CLK_MON_DUTY_EN` defined:
  - CALC state, `duty_pct` port and divider instance exist;
  - `duty_pct` resets to 0 and updates at DONE;
  - on timeout, CALC is skipped and `duty_pct` keeps its previous value.
- Undefined: no CALC state, no `duty_pct` port, no divider logic. MEAS goes straight to DONE.

## Structure
- Shared package `clk_mon_pkg`:
  - FSM state enum;
  - `PCT_W`=7 and `PCT_SCALE`=100 constants.
- Sub-module `clk_mon_sync`: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated once per input.
- The divider stays inline.

## Test plan
All cases use `clk`=100 MHz, `SYNC_STAGES`=2.
- Ref 10 MHz at 50% duty, phase output delayed 40 ns; `start` → `period`=10, `high_time`=5, `phase_lag`=4, `phase_valid`=1, `duty_pct`=50, `done` pulses once.
- Ref period 200 ns at 30% duty, phase output identical to ref → `period`=20, `high_time`=6, `phase_lag`=0, `duty_pct`=30.
- `TIMEOUT`=1000, `mon_ref` held low → `done` with `timeout_err`=1 exactly 1001 cycles after entering ARM; results unchanged.
- `en` dropped midway through MEAS → `busy`=0 next cycle, no `done`, all results keep prior values; a new `start` with `en`=1 measures normally.
- `mon_phase` held low → `phase_valid`=0 and `phase_lag` unchanged; `start` while `busy` is ignored.
- `rst_n` pulsed low during MEAS → all outputs 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clk_monitor measurement block.
// Optional feature macro: CLK_MON_DUTY_EN adds the CALC state used by the
// duty-cycle divider.
package clk_mon_pkg;

    // Width of the duty-cycle result and the percentage scale it is based on
    localparam int PCT_W     = 7;
    localparam int PCT_SCALE = 100;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_MEAS = 3'd2,
`ifdef CLK_MON_DUTY_EN
        ST_CALC = 3'd3,
`endif
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/clk_mon_sync.sv
// Brings one asynchronous clock-like signal into the clk domain and produces
// single-cycle rise and fall pulses. It uses one delay flop behind the
// synchronizer. Every monitored input uses the same depth, so all inputs
// see identical detection latency.
module clk_mon_sync
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchronizer chain followed by the delay flop used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/clk_monitor.sv
// clk_monitor: measures the period and high time of a reference clock. It
// also measures the lag from a reference rise to a rise of a phase-shifted
// copy. Both inputs are sampled against the faster system clock.
// Optional feature macro: CLK_MON_DUTY_EN adds the duty_pct output. It
// also adds a 7-step restoring divider that runs in a CALC state before DONE.
// Intermediate captures are held in shadow registers and committed together
// at the closing reference rise. This keeps the visible results stable when
// the block is disabled or times out partway through a measurement.
module clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             mon_ref,
    input  logic             mon_phase,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] phase_lag,
    output logic             phase_valid,
    output logic             timeout_err
`ifdef CLK_MON_DUTY_EN
    ,
    output logic [PCT_W-1:0] duty_pct
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] ht_shadow;
    logic [CNT_W-1:0] lag_shadow;
    logic             fall_seen;
    logic             phase_seen;

    logic             ref_rise;
    logic             ref_fall;
    logic             phase_rise;
    logic             phase_fall_unused;

`ifdef CLK_MON_DUTY_EN
    localparam int DIV_W = CNT_W + PCT_W;

    logic [DIV_W-1:0] div_rem;
    logic [DIV_W-1:0] div_den;
    logic [PCT_W-1:0] div_quo;
    logic [2:0]       div_iter;
    logic             div_bit;
    logic [DIV_W-1:0] rem_next;
    logic [PCT_W-1:0] quo_next;
`endif

    clk_mon_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_ref (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (mon_ref),
        .rise     (ref_rise),
        .fall     (ref_fall)
    );

    clk_mon_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (mon_phase),
        .rise     (phase_rise),
        .fall     (phase_fall_unused)
    );

    assign cnt_inc = cnt + CNT_W'(1);

`ifdef CLK_MON_DUTY_EN
    // One restoring-division step: subtract the shifted divisor when it fits
    always_comb begin
        div_bit  = (div_rem >= div_den);
        rem_next = div_bit ? (div_rem - div_den) : div_rem;
        quo_next = {div_quo[PCT_W-2:0], div_bit};
    end
`endif

    // Measurement sequencer with registered results, status flags and divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            period      <= '0;
            high_time   <= '0;
            phase_lag   <= '0;
            phase_valid <= 1'b0;
            timeout_err <= 1'b0;
            ht_shadow   <= '0;
            lag_shadow  <= '0;
            fall_seen   <= 1'b0;
            phase_seen  <= 1'b0;
`ifdef CLK_MON_DUTY_EN
            div_rem     <= '0;
            div_den     <= '0;
            div_quo     <= '0;
            div_iter    <= '0;
            duty_pct    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (!en) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state       <= ST_ARM;
                            busy        <= 1'b1;
                            cnt         <= '0;
                            phase_valid <= 1'b0;
                            timeout_err <= 1'b0;
                        end
                    end

                    ST_ARM: begin
                        if (cnt == TIMEOUT_C) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            timeout_err <= 1'b1;
                        end else if (ref_rise) begin
                            state      <= ST_MEAS;
                            cnt        <= '0;
                            fall_seen  <= 1'b0;
                            ht_shadow  <= '0;
                            phase_seen <= phase_rise;
                            lag_shadow <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    ST_MEAS: begin
                        if (cnt == TIMEOUT_C) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            timeout_err <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                            if (ref_rise) begin
                                period    <= cnt_inc;
                                high_time <= ht_shadow;
                                if (phase_seen) begin
                                    phase_lag   <= lag_shadow;
                                    phase_valid <= 1'b1;
                                end else if (phase_rise) begin
                                    phase_lag   <= '0;
                                    phase_valid <= 1'b1;
                                end
`ifdef CLK_MON_DUTY_EN
                                state    <= ST_CALC;
                                div_rem  <= DIV_W'(ht_shadow) * DIV_W'(PCT_SCALE);
                                div_den  <= DIV_W'(cnt_inc) << (PCT_W - 1);
                                div_quo  <= '0;
                                div_iter <= '0;
`else
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end else begin
                                if (ref_fall && !fall_seen) begin
                                    ht_shadow <= cnt_inc;
                                    fall_seen <= 1'b1;
                                end
                                if (phase_rise && !phase_seen) begin
                                    lag_shadow <= cnt_inc;
                                    phase_seen <= 1'b1;
                                end
                            end
                        end
                    end

`ifdef CLK_MON_DUTY_EN
                    ST_CALC: begin
                        div_rem  <= rem_next;
                        div_den  <= div_den >> 1;
                        div_quo  <= quo_next;
                        div_iter <= div_iter + 3'd1;
                        if (div_iter == 3'(PCT_W - 1)) begin
                            duty_pct <= quo_next;
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
`endif

                    ST_DONE: begin
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_monitor.sv
// Self-checking bench for clk_monitor. Reference and phase waveforms are
// generated cycle-synchronously from (period, high, delay) parameters. The
// expected results therefore follow directly from those parameters. A
// compare process checks every idle cycle against the expected values.
module tb_clk_monitor;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 1000;

    typedef enum int {K_NONE, K_NORMAL, K_TIMEOUT, K_ABORT} kind_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             start;
    logic             mon_ref;
    logic             mon_phase;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] phase_lag;
    logic             phase_valid;
    logic             timeout_err;
`ifdef CLK_MON_DUTY_EN
    logic [6:0]       duty_pct;
`endif

    int    total_checks = 0;
    int    bad_checks   = 0;

    int    wave_t      = 0;
    int    wave_p      = 10;
    int    wave_h      = 5;
    int    wave_d      = 0;
    bit    wave_ref_on = 1'b0;
    bit    wave_ph_on  = 1'b0;

    int    exp_period  = 0;
    int    exp_high    = 0;
    int    exp_lag     = 0;
    int    exp_duty    = 0;
    bit    exp_pv      = 1'b0;
    bit    exp_terr    = 1'b0;

    kind_t pend_kind   = K_NONE;
    int    pend_period = 0;
    int    pend_high   = 0;
    int    pend_lag    = 0;
    int    pend_duty   = 0;
    bit    pend_phase  = 1'b0;
    bit    was_busy    = 1'b0;

    clk_monitor #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .start       (start),
        .mon_ref     (mon_ref),
        .mon_phase   (mon_phase),
        .busy        (busy),
        .done        (done),
        .period      (period),
        .high_time   (high_time),
        .phase_lag   (phase_lag),
        .phase_valid (phase_valid),
        .timeout_err (timeout_err)
`ifdef CLK_MON_DUTY_EN
        ,
        .duty_pct    (duty_pct)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual != expected) begin
            bad_checks++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model of one completed measurement of a periodic waveform
    task automatic modelMeasure(input int p, input int h, input int d, input bit ph_on);
        pend_kind   = K_NORMAL;
        pend_period = p;
        pend_high   = h;
        pend_lag    = d;
        pend_phase  = ph_on;
        pend_duty   = (100 * h) / p;
    endtask

    task automatic applyStimulus(input int p, input int h, input int d,
                                 input bit ref_on, input bit ph_on);
        wave_p      = p;
        wave_h      = h;
        wave_d      = d;
        wave_ref_on = ref_on;
        wave_ph_on  = ph_on;
        repeat (3 * p + 10) tick();
    endtask

    task automatic runMeasure(input string tag, input int max_cycles, input bit poke,
                              output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({tag, "_busy_after_start"}, busy, 1);
        while (!seen && lat <= max_cycles) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = poke && (lat == 5);
                tick();
                lat++;
            end
        end
        start = 1'b0;
        checkOutput({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            tick();
            checkOutput({tag, "_done_width"}, done, 0);
        end
        repeat (2) tick();
    endtask

    task automatic waitRef(input bit level, input string tag);
        bit prev;
        bit hit;
        int n;
        prev = mon_ref;
        hit  = 1'b0;
        n    = 0;
        while (!hit && n < 200) begin
            tick();
            n++;
            if (mon_ref == level && prev != level) hit = 1'b1;
            prev = mon_ref;
        end
        checkOutput({tag, "_ref_edge"}, hit, 1);
    endtask

    // Waveform generator: phase is the reference delayed by wave_d cycles
    initial begin
        mon_ref   = 1'b0;
        mon_phase = 1'b0;
        forever begin
            @(negedge clk);
            wave_t++;
            mon_ref   = wave_ref_on && ((wave_t % wave_p) < wave_h);
            mon_phase = wave_ref_on && wave_ph_on &&
                        (((wave_t + wave_p - wave_d) % wave_p) < wave_h);
        end
    end

    // Compare process: applies the model on completion, checks every idle cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_period = 0;
                exp_high   = 0;
                exp_lag    = 0;
                exp_duty   = 0;
                exp_pv     = 1'b0;
                exp_terr   = 1'b0;
                pend_kind  = K_NONE;
                was_busy   = 1'b0;
            end else begin
                if (!was_busy && busy && pend_kind == K_NONE)
                    checkOutput("cmp_unexpected_busy", busy, 0);
                if (done) begin
                    if (pend_kind == K_NORMAL) begin
                        exp_period = pend_period;
                        exp_high   = pend_high;
                        exp_duty   = pend_duty;
                        exp_terr   = 1'b0;
                        exp_pv     = pend_phase;
                        if (pend_phase) exp_lag = pend_lag;
                    end else if (pend_kind == K_TIMEOUT) begin
                        exp_terr = 1'b1;
                        exp_pv   = 1'b0;
                    end else begin
                        checkOutput("cmp_unexpected_done", done, 0);
                    end
                    pend_kind = K_NONE;
                end else if (was_busy && !busy) begin
                    if (pend_kind != K_ABORT)
                        checkOutput("cmp_busy_fell_without_done", done, 1);
                    exp_terr  = 1'b0;
                    exp_pv    = 1'b0;
                    pend_kind = K_NONE;
                end
                if (!busy) begin
                    checkOutput("cmp_period", period, exp_period);
                    checkOutput("cmp_high_time", high_time, exp_high);
                    checkOutput("cmp_phase_lag", phase_lag, exp_lag);
                    checkOutput("cmp_phase_valid", phase_valid, exp_pv);
                    checkOutput("cmp_timeout_err", timeout_err, exp_terr);
`ifdef CLK_MON_DUTY_EN
                    checkOutput("cmp_duty_pct", duty_pct, exp_duty);
`endif
                end
                was_busy = busy;
            end
        end
    end

    // Global time bound so the run always ends
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=%0d expected=%0d", 1, 0);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed cases, then randomized measurements
    initial begin
        int lat;
        int p;
        int h;
        int d;
        bit ph;

        rst_n = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_period", period, 0);
        checkOutput("reset_high_time", high_time, 0);
        checkOutput("reset_phase_lag", phase_lag, 0);
        checkOutput("reset_phase_valid", phase_valid, 0);
        checkOutput("reset_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        tick();
        en = 1'b1;

        applyStimulus(10, 5, 4, 1'b1, 1'b1);
        modelMeasure(10, 5, 4, 1'b1);
        runMeasure("tp1", 60, 1'b0, lat);
        checkOutput("tp1_period", period, 10);
        checkOutput("tp1_high_time", high_time, 5);
        checkOutput("tp1_phase_lag", phase_lag, 4);
        checkOutput("tp1_phase_valid", phase_valid, 1);
`ifdef CLK_MON_DUTY_EN
        checkOutput("tp1_duty", duty_pct, 50);
`endif

        applyStimulus(20, 6, 0, 1'b1, 1'b1);
        modelMeasure(20, 6, 0, 1'b1);
        runMeasure("tp2", 90, 1'b0, lat);
        checkOutput("tp2_period", period, 20);
        checkOutput("tp2_high_time", high_time, 6);
        checkOutput("tp2_phase_lag", phase_lag, 0);
`ifdef CLK_MON_DUTY_EN
        checkOutput("tp2_duty", duty_pct, 30);
`endif

        applyStimulus(10, 5, 0, 1'b0, 1'b0);
        pend_kind = K_TIMEOUT;
        runMeasure("tmo", TIMEOUT + 100, 1'b0, lat);
        checkOutput("tmo_latency", lat, TIMEOUT + 1);
        checkOutput("tmo_flag", timeout_err, 1);
        checkOutput("tmo_period_kept", period, 20);
        checkOutput("tmo_high_kept", high_time, 6);

        applyStimulus(10, 5, 4, 1'b1, 1'b1);
        modelMeasure(10, 5, 4, 1'b1);
        runMeasure("recover", 60, 1'b0, lat);
        checkOutput("recover_flag_clear", timeout_err, 0);

        applyStimulus(16, 8, 0, 1'b1, 1'b0);
        modelMeasure(16, 8, 0, 1'b0);
        runMeasure("nophase", 80, 1'b1, lat);
        checkOutput("nophase_valid", phase_valid, 0);
        checkOutput("nophase_lag_kept", phase_lag, 4);
        checkOutput("nophase_period", period, 16);

        applyStimulus(20, 6, 3, 1'b1, 1'b1);
        waitRef(1'b0, "abort_fall");
        modelMeasure(20, 6, 3, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitRef(1'b1, "abort_rise");
        repeat (5) tick();
        checkOutput("abort_busy_before", busy, 1);
        pend_kind = K_ABORT;
        en = 1'b0;
        tick();
        checkOutput("abort_busy_after", busy, 0);
        lat = 0;
        repeat (40) begin
            tick();
            if (done) lat++;
        end
        checkOutput("abort_no_done", lat, 0);
        checkOutput("abort_period_kept", period, 16);
        en = 1'b1;
        tick();
        modelMeasure(20, 6, 3, 1'b1);
        runMeasure("after_abort", 90, 1'b0, lat);
        checkOutput("after_abort_lag", phase_lag, 3);

        for (int i = 0; i < 25; i++) begin
            p  = $urandom_range(40, 2);
            h  = $urandom_range(p - 1, 1);
            d  = $urandom_range(p - 1, 0);
            ph = ($urandom_range(4, 0) != 0);
            applyStimulus(p, h, d, 1'b1, ph);
            modelMeasure(p, h, d, ph);
            runMeasure("rand", 3 * p + 20, 1'b0, lat);
        end

        applyStimulus(12, 4, 2, 1'b1, 1'b1);
        waitRef(1'b0, "rst_fall");
        modelMeasure(12, 4, 2, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitRef(1'b1, "rst_rise");
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_period", period, 0);
        checkOutput("midrst_high_time", high_time, 0);
        checkOutput("midrst_phase_lag", phase_lag, 0);
        checkOutput("midrst_phase_valid", phase_valid, 0);
        checkOutput("midrst_timeout_err", timeout_err, 0);
`ifdef CLK_MON_DUTY_EN
        checkOutput("midrst_duty", duty_pct, 0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        modelMeasure(12, 4, 2, 1'b1);
        runMeasure("post_rst", 60, 1'b0, lat);
        checkOutput("post_rst_period", period, 12);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
